reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Issue controller for the ID stage register file.
//  - Tracks in-flight writes per architectural register with a pending counter.
//  - Stalls ID while a source of the decoded instruction has a pending write.
//  - Counts pending writes at issue; retires them at writeback.
//  - Drives the register-file write enable and exposes a busy vector and stall statistics.
// PARAMETERS
//  NREG    32  number of architectural registers (x0 hard-wired zero)
//  ADDR_W  5   register address width, clog2(NREG)
//  CNT_W   2   width of per-register pending-write counter (max 2**CNT_W-1 in flight)
// PORTS
//  clk           in   1       single clock, all state on posedge
//  reset         in   1       synchronous, active-high
//  issue_valid   in   1       ID holds a decoded instruction
//  inst_ID       in   32      instruction in ID: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20]
//  issue_ready   out  1       no hazard; instruction advances to EX this cycle
//  wb_valid      in   1       writeback of a result this cycle
//  wb_rd         in   ADDR_W  destination of the writeback
//  reg_write_en  out  1       register-file write enable = wb_valid & (wb_rd!=0)
//  busy_vec      out  NREG    bit i = (cnt[i]!=0); bit 0 always 0
//  stall_cnt     out  32      cycles with issue_valid & !issue_ready, saturating
//  underflow_err out  1       sticky: writeback retired a register with cnt==0
// BEHAVIOUR
//  Reset (sync, active-high)
//  - All cnt[i]=0, busy_vec=0, stall_cnt=0, underflow_err=0.
//  - reset wins over any simultaneous issue or writeback.
//  Operand usage, decoded from opcode
//  - uses_rs1: all opcodes except LUI(0110111), AUIPC(0010111), JAL(1101111).
//  - uses_rs2: BRANCH(1100011), STORE(0100011), OP(0110011) only.
//  - writes_rd: all opcodes except BRANCH, STORE.
//  - Unknown opcode: treated as using rs1, rs2 and rd (conservative).
//  - Register 0 is never a hazard source and is never counted.
//  Readiness (combinational, same cycle)
//  - issue_ready = !(uses_rs1 & rs1!=0 & cnt[rs1]!=0)
//                & !(uses_rs2 & rs2!=0 & cnt[rs2]!=0)
//                & !(writes_rd & rd!=0 & cnt[rd]==MAX).
//  - No bypass from writeback: the register file writes at the posedge, so a
//    source retired at wb in cycle N makes issue_ready rise in cycle N+1.
//  - issue_ready is driven regardless of issue_valid. It is a pure function of
//    inst_ID and state, and has no dependence on wb inputs in the same cycle.
//  Counter update on posedge
//  - fire = issue_valid & issue_ready.
//  - inc = fire & writes_rd & rd!=0; dec = wb_valid & wb_rd!=0.
//  - inc and dec to the same register in the same cycle: cnt unchanged.
//  - inc and dec to different registers: both apply.
//  - dec with cnt==0: cnt stays 0 and underflow_err<=1 (sticky until reset).
//  - inc is never applied at MAX, because issue_ready blocks it.
//  stall_cnt
//  - +1 each cycle with issue_valid & !issue_ready.
//  - Holds at 32'hFFFF_FFFF.
//  Latency
//  - Issue to busy_vec bit visible: 1 cycle.
//  - Writeback to busy_vec clear: 1 cycle, when cnt reaches 0.
// TESTING
//  1. Reset with random inputs held -> busy_vec=0, stall_cnt=0, underflow_err=0, issue_ready=1 for any inst.
//  2. Issue ADD x5,x1,x2; next cycle ADD x6,x5,x3 -> busy_vec[5]=1, issue_ready=0;
//     wb_valid, wb_rd=5 in cycle N -> issue_ready=1 in N+1 (not N); stall_cnt counts stall cycles exactly.
//  3. Issue ADDI x7 three times with no wb (CNT_W=2) -> cnt[7]=3; fourth write to x7 stalls;
//     one wb_rd=7 -> fourth issues the next cycle.
//  4. Same cycle: issue writing x9 while wb_rd=9 and cnt[9]=1 -> cnt[9] stays 1, busy_vec[9]=1.
//  5. Issue ADDI x0,x0,1; wb_rd=0 -> busy_vec=0, reg_write_en=0, underflow_err=0;
//     LUI x4 with garbage rs1 field busy -> no stall.
//  6. wb_rd=12 with cnt[12]=0 -> underflow_err=1, cnt[12]=0; stays 1 until reset;
//     reset mid-stall clears all state and issue_ready=1 the next cycle.

Source files
------------

// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bus between the ID stage and the register scoreboard.
// The master (ID/WB side) drives instructions and writebacks.
// The slave (scoreboard) returns readiness and the register-file write enable.
interface reg_scoreboard_if #(
    parameter int ADDR_W = 5
);
    logic              issue_valid;
    logic [31:0]       inst_ID;
    logic              issue_ready;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic              reg_write_en;

    modport master (
        output issue_valid, inst_ID, wb_valid, wb_rd,
        input  issue_ready, reg_write_en
    );

    modport slave (
        input  issue_valid, inst_ID, wb_valid, wb_rd,
        output issue_ready, reg_write_en
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage: tracks in-flight writes per
// architectural register and stalls issue on read-after-write hazards or
// when a destination's pending-write counter is full.

// Per-register pending-write counter. Simultaneous inc and dec cancel out.
// A dec on an empty counter is reported and leaves the counter at zero.
module reg_cnt_cell #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    // Counter update; inc is never presented at MAX since issue is held off.
    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && !dec)
            cnt <= cnt + 1'b1;
        else if (dec && !inc && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Retiring a register with nothing in flight (and no offsetting issue).
    always_comb begin
        underflow = dec && !inc && (cnt == '0);
    end
endmodule

module reg_scoreboard #(
    parameter int NREG   = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 2
) (
    input  logic             clk,
    input  logic             reset,
    reg_scoreboard_if.slave  bus,
    output logic [NREG-1:0]  busy_vec,
    output logic [31:0]      stall_cnt,
    output logic             underflow_err
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [6:0]        opcode;
    logic [ADDR_W-1:0] rd, rs1, rs2;
    logic              uses_rs1, uses_rs2, writes_rd;
    logic              haz_rs1, haz_rs2, haz_rd;
    logic              fire, inc, dec;
    logic [NREG-1:0]   inc_vec, dec_vec, uf_vec;
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic              unused_inst;

    assign opcode = bus.inst_ID[6:0];
    assign rd     = bus.inst_ID[11:7];
    assign rs1    = bus.inst_ID[19:15];
    assign rs2    = bus.inst_ID[24:20];
    // funct3/funct7 do not affect operand usage.
    assign unused_inst = ^{bus.inst_ID[31:25], bus.inst_ID[14:12]};

    // Operand usage from opcode; unknown opcodes assume every field is live.
    always_comb begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                uses_rs1 = 1'b0;
                uses_rs2 = 1'b0;
            end
            OP_BRANCH, OP_STORE: begin
                writes_rd = 1'b0;
            end
            OP_OP: begin
                // all three fields in use
            end
            OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
                uses_rs2 = 1'b0;
            end
            default: begin
                // conservative: rs1, rs2 and rd all considered
            end
        endcase
    end

    // Hazard detection: pure function of the instruction and counter state,
    // no forwarding from a same-cycle writeback.
    always_comb begin
        haz_rs1 = uses_rs1  && (rs1 != '0) && (cnt[rs1] != '0);
        haz_rs2 = uses_rs2  && (rs2 != '0) && (cnt[rs2] != '0);
        haz_rd  = writes_rd && (rd  != '0) && (cnt[rd]  == CNT_MAX);
        bus.issue_ready = !(haz_rs1 || haz_rs2 || haz_rd);
    end

    assign fire = bus.issue_valid && bus.issue_ready;
    assign inc  = fire && writes_rd && (rd != '0);
    assign dec  = bus.wb_valid && (bus.wb_rd != '0);
    assign bus.reg_write_en = dec;

    // One-hot increment/decrement selects for the counter array.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc) inc_vec[rd]        = 1'b1;
        if (dec) dec_vec[bus.wb_rd] = 1'b1;
    end

    // Counter array; x0 has no counter and never reports busy.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign cnt[i]    = '0;
            assign uf_vec[i] = 1'b0;
            logic unused_x0;
            assign unused_x0 = inc_vec[i] ^ dec_vec[i];
        end else begin : g_cell
            reg_cnt_cell #(.CNT_W(CNT_W)) u_cell (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc_vec[i]),
                .dec       (dec_vec[i]),
                .cnt       (cnt[i]),
                .underflow (uf_vec[i])
            );
        end
        assign busy_vec[i] = (cnt[i] != '0);
    end

    // Stall statistics, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (bus.issue_valid && !bus.issue_ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset)
            underflow_err <= 1'b0;
        else if (|uf_vec)
            underflow_err <= 1'b1;
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench for reg_scoreboard. Each step drives inputs and
// pushes its expectations: combinational ones are checked before the clock
// edge, registered ones just after it.
module tb_reg_scoreboard;
    localparam int NREG = 32, ADDR_W = 5, CNT_W = 2;

    localparam int S_BUSY = 0, S_STALL = 1, S_UF = 2, S_RDY = 3, S_WEN = 4;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic [NREG-1:0] busy_vec;
    logic [31:0]     stall_cnt;
    logic            underflow_err;

    exp_t q_pre[$];
    exp_t q_post[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    reg_scoreboard_if #(.ADDR_W(ADDR_W)) bus ();

    reg_scoreboard #(.NREG(NREG), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .busy_vec      (busy_vec),
        .stall_cnt     (stall_cnt),
        .underflow_err (underflow_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_add(input logic [4:0] rd, rs1, rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_addi(input logic [4:0] rd, rs1);
        return {12'd1, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] u_lui(input logic [4:0] rd, junk);
        return {7'b0, junk, junk, 3'b000, rd, 7'b0110111};
    endfunction

    function automatic logic [31:0] bit_of(input int r);
        logic [31:0] v;
        v = 32'd1 << r;
        return v;
    endfunction

    function automatic logic [31:0] observe(input int sig);
        case (sig)
            S_BUSY:  return busy_vec;
            S_STALL: return stall_cnt;
            S_UF:    return {31'd0, underflow_err};
            S_RDY:   return {31'd0, bus.issue_ready};
            default: return {31'd0, bus.reg_write_en};
        endcase
    endfunction

    task automatic pre(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sig = sig; e.val = val;
        q_pre.push_back(e);
    endtask

    task automatic post(input string tag, input int sig, input logic [31:0] val);
        exp_t e;
        e.tag = tag; e.sig = sig; e.val = val;
        q_post.push_back(e);
    endtask

    task automatic drain(input bit use_post);
        exp_t e;
        logic [31:0] obs;
        while (use_post ? q_post.size() > 0 : q_pre.size() > 0) begin
            e   = use_post ? q_post.pop_front() : q_pre.pop_front();
            obs = observe(e.sig);
            n_assert++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] inst,
                         input logic wv, input logic [4:0] wrd);
        bus.issue_valid = iv;
        bus.inst_ID     = inst;
        bus.wb_valid    = wv;
        bus.wb_rd       = wrd;
    endtask

    // Check combinational expectations, clock once, check registered ones.
    task automatic step();
        #1;
        drain(1'b0);
        @(posedge clk);
        #1;
        drain(1'b1);
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 5'd0);

        // 1: reset wins over random traffic
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b1, 5'($urandom));
            post("rst_busy", S_BUSY, 32'd0);
            post("rst_stall", S_STALL, 32'd0);
            post("rst_uf", S_UF, 32'd0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, $urandom, 1'b0, 5'd0);
            pre("rst_ready", S_RDY, 32'd1);
            step();
        end
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 5'd0);
        step();

        // 2: RAW hazard on x5, no bypass from writeback
        drive(1'b1, r_add(5'd5, 5'd1, 5'd2), 1'b0, 5'd0);
        pre("raw_issue_rdy", S_RDY, 32'd1);
        post("raw_busy5", S_BUSY, bit_of(5));
        step();
        drive(1'b1, r_add(5'd6, 5'd5, 5'd3), 1'b0, 5'd0);
        pre("raw_stall_rdy", S_RDY, 32'd0);
        post("raw_stall1", S_STALL, 32'd1);
        step();
        drive(1'b1, r_add(5'd6, 5'd5, 5'd3), 1'b1, 5'd5);
        pre("raw_nobypass", S_RDY, 32'd0);
        pre("raw_wen", S_WEN, 32'd1);
        post("raw_busy_clr", S_BUSY, 32'd0);
        post("raw_stall2", S_STALL, 32'd2);
        step();
        drive(1'b1, r_add(5'd6, 5'd5, 5'd3), 1'b0, 5'd0);
        pre("raw_ready_n1", S_RDY, 32'd1);
        post("raw_busy6", S_BUSY, bit_of(6));
        post("raw_stall_hold", S_STALL, 32'd2);
        step();
        drive(1'b0, 32'd0, 1'b1, 5'd6);
        post("raw_retire6", S_BUSY, 32'd0);
        step();

        // 3: saturate x7 counter, fourth write stalls until one retires
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i_addi(5'd7, 5'd0), 1'b0, 5'd0);
            pre("max_issue_rdy", S_RDY, 32'd1);
            post("max_busy7", S_BUSY, bit_of(7));
            step();
        end
        drive(1'b1, i_addi(5'd7, 5'd0), 1'b0, 5'd0);
        pre("max_full_rdy", S_RDY, 32'd0);
        post("max_stall3", S_STALL, 32'd3);
        step();
        drive(1'b1, i_addi(5'd7, 5'd0), 1'b1, 5'd7);
        pre("max_wb_nobypass", S_RDY, 32'd0);
        post("max_stall4", S_STALL, 32'd4);
        step();
        drive(1'b1, i_addi(5'd7, 5'd0), 1'b0, 5'd0);
        pre("max_fourth_rdy", S_RDY, 32'd1);
        post("max_busy7_again", S_BUSY, bit_of(7));
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 1'b1, 5'd7);
            post("max_drain_busy", S_BUSY, (i == 2) ? 32'd0 : bit_of(7));
            step();
        end
        drive(1'b0, 32'd0, 1'b0, 5'd0);
        post("max_no_uf", S_UF, 32'd0);
        step();

        // 4: issue and writeback to x9 in the same cycle cancel out
        drive(1'b1, i_addi(5'd9, 5'd0), 1'b0, 5'd0);
        post("same_busy9", S_BUSY, bit_of(9));
        step();
        drive(1'b1, i_addi(5'd9, 5'd0), 1'b1, 5'd9);
        pre("same_rdy", S_RDY, 32'd1);
        post("same_busy9_kept", S_BUSY, bit_of(9));
        step();
        drive(1'b0, 32'd0, 1'b1, 5'd9);
        post("same_cnt_was1", S_BUSY, 32'd0);
        post("same_no_uf", S_UF, 32'd0);
        step();

        // 5: x0 never tracked; LUI ignores garbage source fields
        drive(1'b1, i_addi(5'd0, 5'd0), 1'b1, 5'd0);
        pre("x0_rdy", S_RDY, 32'd1);
        pre("x0_wen", S_WEN, 32'd0);
        post("x0_busy", S_BUSY, 32'd0);
        post("x0_uf", S_UF, 32'd0);
        step();
        drive(1'b1, i_addi(5'd3, 5'd0), 1'b0, 5'd0);
        post("lui_busy3", S_BUSY, bit_of(3));
        step();
        drive(1'b1, u_lui(5'd4, 5'd3), 1'b0, 5'd0);
        pre("lui_no_stall", S_RDY, 32'd1);
        post("lui_busy34", S_BUSY, bit_of(3) | bit_of(4));
        post("lui_stall_hold", S_STALL, 32'd4);
        step();
        drive(1'b0, 32'd0, 1'b1, 5'd3);
        step();
        drive(1'b0, 32'd0, 1'b1, 5'd4);
        post("lui_drained", S_BUSY, 32'd0);
        step();

        // 6: underflow is sticky; reset mid-stall clears everything
        drive(1'b0, 32'd0, 1'b1, 5'd12);
        pre("uf_wen", S_WEN, 32'd1);
        post("uf_set", S_UF, 32'd1);
        post("uf_busy", S_BUSY, 32'd0);
        step();
        drive(1'b0, 32'd0, 1'b0, 5'd0);
        post("uf_sticky", S_UF, 32'd1);
        step();
        drive(1'b1, i_addi(5'd8, 5'd0), 1'b0, 5'd0);
        post("rs_busy8", S_BUSY, bit_of(8));
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, r_add(5'd10, 5'd8, 5'd8), 1'b0, 5'd0);
            pre("rs_stall_rdy", S_RDY, 32'd0);
            post("rs_stall_cnt", S_STALL, 32'(5 + i));
            post("uf_still", S_UF, 32'd1);
            step();
        end
        reset = 1'b1;
        pre("rs_rdy_in_reset", S_RDY, 32'd0);
        post("rs_busy0", S_BUSY, 32'd0);
        post("rs_stall0", S_STALL, 32'd0);
        post("rs_uf0", S_UF, 32'd0);
        step();
        reset = 1'b0;
        pre("rs_rdy_after", S_RDY, 32'd1);
        post("rs_busy10", S_BUSY, bit_of(10));
        post("rs_stall_zero", S_STALL, 32'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
